// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler and RAW/WAW hazard scoreboard for the 32x32 register file write port.
// Optional macro SCOREBOARD_BYPASS_EN lets a hazard clear in the same cycle its writeback transfers.
module regfile_wb_scheduler #(
    parameter int DATA_W    = 32,
    parameter int AGE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        issue_rs,
    input  logic [4:0]        issue_rt,
    input  logic              issue_uses_rs,
    input  logic              issue_uses_rt,
    input  logic              issue_writes_rd,
    output logic              issue_stall,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [4:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              link_valid,
    input  logic [DATA_W-1:0] link_data,
    output logic              link_ready,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [31:0]       pending
);

    localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);
    localparam int LINK = 0;
    localparam int MEM  = 1;
    localparam int ALU  = 2;

    logic [2:0]        ch_valid;
    logic [2:0]        starved;
    logic [2:0]        grant;
    logic [3:0]        age_q [3];
    logic              xfer;
    logic [4:0]        xfer_rd;
    logic [DATA_W-1:0] xfer_data;
    logic              rf_we_q;
    logic [31:0]       pending_q;
    logic [31:0]       hazard_vec;
    logic              issue_accept;
    logic [31:0]       sb_set;
    logic [31:0]       sb_clr;

    assign ch_valid = {alu_valid, mem_valid, link_valid};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            starved[i] = ch_valid[i] && (age_q[i] == AGE_MAX);
        end
    end

    // Starved requesters outrank everyone; base priority link > mem > alu breaks ties.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant = 3'b000;
        if (!reset) begin
            if (|starved) begin
                if (starved[LINK])     grant = 3'b001;
                else if (starved[MEM]) grant = 3'b010;
                else                   grant = 3'b100;
            end else if (ch_valid[LINK]) begin
                grant = 3'b001;
            end else if (ch_valid[MEM]) begin
                grant = 3'b010;
            end else if (ch_valid[ALU]) begin
                grant = 3'b100;
            end
        end
    end

    assign link_ready = grant[LINK];
    assign mem_ready  = grant[MEM];
    assign alu_ready  = grant[ALU];
    assign xfer       = |grant;

    always_comb begin
        xfer_rd   = alu_rd;
        xfer_data = alu_data;
        if (grant[LINK]) begin
            xfer_rd   = 5'd31;
            xfer_data = link_data;
        end else if (grant[MEM]) begin
            xfer_rd   = mem_rd;
            xfer_data = mem_data;
        end
    end

    always_comb begin
        hazard_vec = pending_q;
`ifdef SCOREBOARD_BYPASS_EN
        if (xfer) hazard_vec[xfer_rd] = 1'b0;
`endif
    end

    assign issue_stall = !reset && issue_valid &&
                         ((issue_uses_rs   && hazard_vec[issue_rs]) ||
                          (issue_uses_rt   && hazard_vec[issue_rt]) ||
                          (issue_writes_rd && hazard_vec[issue_rd]));

    assign issue_accept = !reset && issue_valid && !issue_stall;
    assign sb_set = (issue_accept && issue_writes_rd) ? (32'd1 << issue_rd) : 32'd0;
    assign sb_clr = xfer ? (32'd1 << xfer_rd) : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q   <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= '0;
            pending_q <= 32'd0;
            for (int i = 0; i < 3; i++) age_q[i] <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rf_we_q   <= xfer;
            pending_q <= (pending_q & ~sb_clr) | sb_set;
            if (xfer) begin
                rf_waddr <= xfer_rd;
                rf_wdata <= xfer_data;
            end
            for (int i = 0; i < 3; i++) begin
                if (!ch_valid[i] || grant[i]) age_q[i] <= 4'd0;
                else if (age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + 4'd1;
            end
        end
    end

    // Reset drops an in-flight write and the scoreboard in the very cycle it is asserted.
    assign rf_we   = rf_we_q && !reset;
    assign pending = reset ? 32'd0 : pending_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler (AGE_LIMIT=4, either bypass build).
`timescale 1ns/1ps
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_uses_rs, issue_uses_rt, issue_writes_rd;
    logic [4:0]  issue_rd, issue_rs, issue_rt;
    logic        issue_stall;
    logic        alu_valid, mem_valid, link_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data, link_data;
    logic        alu_ready, mem_ready, link_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int checks   = 0;
    int failures = 0;

    regfile_wb_scheduler #(.DATA_W(32), .AGE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt), .issue_writes_rd(issue_writes_rd),
        .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .link_valid(link_valid), .link_data(link_data), .link_ready(link_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one cycle and land 1ns after the edge; combinational checks go at a further #1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] readies();
        return {29'd0, link_ready, mem_ready, alu_ready};
    endfunction

    initial begin
        reset = 1'b1;
        issue_valid = 0; issue_uses_rs = 0; issue_uses_rt = 0; issue_writes_rd = 0;
        issue_rd = 0; issue_rs = 0; issue_rt = 0;
        alu_valid = 0; mem_valid = 0; link_valid = 0;
        alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0; link_data = 0;
        step();
        alu_valid = 1; issue_valid = 1; issue_writes_rd = 1;
        #1;
        check("rst_ready", readies(), 32'd0);
        check("rst_stall", {31'd0, issue_stall}, 32'd0);
        step();
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_pending", pending, 32'd0);
        alu_valid = 0; issue_valid = 0; issue_writes_rd = 0;
        reset = 1'b0;
        step();
        check("idle_rf_we", {31'd0, rf_we}, 32'd0);

        // Single ALU write
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 check("alu_ready", readies(), 32'b001);
        step();
        alu_valid = 0;
        check("alu_we", {31'd0, rf_we}, 32'd1);
        check("alu_waddr", {27'd0, rf_waddr}, 32'd5);
        check("alu_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        check("alu_we_drop", {31'd0, rf_we}, 32'd0);
        check("alu_waddr_hold", {27'd0, rf_waddr}, 32'd5);
        check("alu_wdata_hold", rf_wdata, 32'hDEADBEEF);
        check("alu_pending_clr", pending, 32'd0);

        // Link write
        link_valid = 1; link_data = 32'h40;
        #1 check("link_ready", readies(), 32'b100);
        step();
        link_valid = 0;
        check("link_waddr", {27'd0, rf_waddr}, 32'd31);
        check("link_wdata", rf_wdata, 32'h40);
        step();

        // Three-way contention: link x4, mem starved at cycle 4, alu starved at cycle 5
        link_valid = 1; link_data = 32'h1;
        mem_valid  = 1; mem_rd = 5'd2; mem_data = 32'h2;
        alu_valid  = 1; alu_rd = 5'd3; alu_data = 32'h3;
        for (int c = 0; c < 6; c++) begin
            logic [31:0] exp_g;
            logic [31:0] exp_a;
            exp_g = (c < 4) ? 32'b100 : (c == 4) ? 32'b010 : 32'b001;
            exp_a = (c < 4) ? 32'd31  : (c == 4) ? 32'd2   : 32'd3;
            #1 check($sformatf("cont_grant_c%0d", c), readies(), exp_g);
            step();
            if (c == 5) begin
                link_valid = 0; mem_valid = 0; alu_valid = 0;
            end
            check($sformatf("cont_waddr_c%0d", c), {27'd0, rf_waddr}, exp_a);
        end
        step();

        // RAW stall on r7 released by a mem writeback
        issue_valid = 1; issue_rd = 5'd7; issue_writes_rd = 1;
        #1 check("raw_first_stall", {31'd0, issue_stall}, 32'd0);
        step();
        issue_rd = 5'd8; issue_rs = 5'd7; issue_uses_rs = 1;
        #1;
        check("raw_pending7", pending, 32'h0000_0080);
        check("raw_stall_a", {31'd0, issue_stall}, 32'd1);
        step();
        check("raw_stall_b", {31'd0, issue_stall}, 32'd1);
        mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h77;
        #1 check("raw_mem_ready", readies(), 32'b010);
`ifdef SCOREBOARD_BYPASS_EN
        check("raw_stall_N", {31'd0, issue_stall}, 32'd0);
        step();
        mem_valid = 0; issue_valid = 0; issue_uses_rs = 0;
        check("raw_wdata", rf_wdata, 32'h77);
        check("raw_pending_N1", pending, 32'h0000_0100);
`else
        check("raw_stall_N", {31'd0, issue_stall}, 32'd1);
        step();
        mem_valid = 0;
        #1;
        check("raw_wdata", rf_wdata, 32'h77);
        check("raw_stall_N1", {31'd0, issue_stall}, 32'd0);
        check("raw_pending_N1", pending, 32'd0);
        step();
        issue_valid = 0; issue_uses_rs = 0;
        check("raw_pending_N2", pending, 32'h0000_0100);
`endif
        alu_valid = 1; alu_rd = 5'd8; alu_data = 32'h8;
        step();
        alu_valid = 0;
        check("r8_cleared", pending, 32'd0);

        // Same-cycle writeback to r9 and accepted issue with rd=9: set wins
        alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h9;
        issue_valid = 1; issue_rd = 5'd9; issue_writes_rd = 1;
        #1;
        check("sc_stall", {31'd0, issue_stall}, 32'd0);
        check("sc_ready", readies(), 32'b001);
        step();
        alu_valid = 0; issue_valid = 0;
        check("sc_pending9", pending, 32'h0000_0200);
        check("sc_waddr", {27'd0, rf_waddr}, 32'd9);
        mem_valid = 1; mem_rd = 5'd9; mem_data = 32'h99;
        step();
        mem_valid = 0;
        check("sc_cleared", pending, 32'd0);

        // Reset mid-write
        issue_valid = 1; issue_rd = 5'd4; issue_writes_rd = 1;
        step();
        issue_valid = 0;
        check("rm_pending4", pending, 32'h0000_0010);
        alu_valid = 1; alu_rd = 5'd12; alu_data = 32'hC;
        #1 check("rm_ready_N", readies(), 32'b001);
        step();
        reset = 1; alu_valid = 0; mem_valid = 1; link_valid = 1; issue_valid = 1;
        #1;
        check("rm_we_N1", {31'd0, rf_we}, 32'd0);
        check("rm_pending_N1", pending, 32'd0);
        check("rm_ready_N1", readies(), 32'd0);
        check("rm_stall_N1", {31'd0, issue_stall}, 32'd0);
        step();
        reset = 0; mem_valid = 0; link_valid = 0; issue_valid = 0;
        check("rm_we_after", {31'd0, rf_we}, 32'd0);
        check("rm_pending_after", pending, 32'd0);
        step();
        check("rm_we_after2", {31'd0, rf_we}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
